// File: rtl/issue_scheduler_if.sv
// Dispatch / wakeup / issue bundle between the rename-dispatch stage,
// writeback and the out-of-order issue scheduler.
interface issue_scheduler_if #(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = 7,
    parameter int PAYLOAD_W = 32
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                 mispredict;
    logic                 disp_valid;
    logic                 disp_ready;
    logic [TAG_W-1:0]     disp_ps1;
    logic [TAG_W-1:0]     disp_ps2;
    logic                 disp_ps1_rdy;
    logic                 disp_ps2_rdy;
    logic [TAG_W-1:0]     disp_pd;
    logic [PAYLOAD_W-1:0] disp_payload;
    logic                 wb_valid;
    logic [TAG_W-1:0]     wb_tag;
    logic                 issue_valid;
    logic                 issue_ready;
    logic [TAG_W-1:0]     issue_ps1;
    logic [TAG_W-1:0]     issue_ps2;
    logic [TAG_W-1:0]     issue_pd;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic [OCC_W-1:0]     occupancy;

    // Pipeline side: dispatch, writeback and the functional unit.
    modport master (
        output mispredict, disp_valid, disp_ps1, disp_ps2, disp_ps1_rdy,
               disp_ps2_rdy, disp_pd, disp_payload, wb_valid, wb_tag,
               issue_ready,
        input  disp_ready, issue_valid, issue_ps1, issue_ps2, issue_pd,
               issue_payload, occupancy
    );

    // Scheduler side.
    modport slave (
        input  mispredict, disp_valid, disp_ps1, disp_ps2, disp_ps1_rdy,
               disp_ps2_rdy, disp_pd, disp_payload, wb_valid, wb_tag,
               issue_ready,
        output disp_ready, issue_valid, issue_ps1, issue_ps2, issue_pd,
               issue_payload, occupancy
    );
endinterface

// File: rtl/issue_scheduler.sv
// Out-of-order issue scheduler: collapsing queue (entry 0 oldest), wakeup
// by writeback tag broadcast, oldest-ready select, full flush on mispredict.

// Per-slot source wakeup: a source becomes ready when a nonzero broadcast
// tag matches it; ready bits are sticky, so the old value is ORed in.
module issue_scheduler_wake #(
    parameter int TAG_W = 7
) (
    input  logic [TAG_W-1:0] ps1_i,
    input  logic [TAG_W-1:0] ps2_i,
    input  logic             rdy1_i,
    input  logic             rdy2_i,
    input  logic             wb_valid_i,
    input  logic [TAG_W-1:0] wb_tag_i,
    output logic             rdy1_o,
    output logic             rdy2_o
);
    logic wb_hit;

    // Tag 0 is x0 and never broadcast as a real wakeup.
    always_comb begin
        wb_hit = wb_valid_i && (wb_tag_i != '0);
        rdy1_o = rdy1_i | (wb_hit && (wb_tag_i == ps1_i));
        rdy2_o = rdy2_i | (wb_hit && (wb_tag_i == ps2_i));
    end
endmodule

module issue_scheduler #(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = 7,
    parameter int PAYLOAD_W = 32
) (
    input logic              clk_i,
    input logic              rst_i,
    issue_scheduler_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic                 valid;
        logic                 rdy1;
        logic                 rdy2;
        logic [TAG_W-1:0]     ps1;
        logic [TAG_W-1:0]     ps2;
        logic [TAG_W-1:0]     pd;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    // One extra empty slot so the top entry can shift in "nothing".
    entry_t           woken [DEPTH+1];
    entry_t           new_ent;
    logic [DEPTH-1:0] wk1, wk2;
    logic             new_rdy1, new_rdy2;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] wr_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             disp_ready_w;
    logic             issue_valid_w;
    logic             accept;
    logic             fire;

    // Wakeup compare for every stored entry.
    for (genvar i = 0; i < DEPTH; i++) begin : g_wake
        issue_scheduler_wake #(.TAG_W(TAG_W)) u_wake (
            .ps1_i      (ent_q[i].ps1),
            .ps2_i      (ent_q[i].ps2),
            .rdy1_i     (ent_q[i].rdy1),
            .rdy2_i     (ent_q[i].rdy2),
            .wb_valid_i (bus.wb_valid),
            .wb_tag_i   (bus.wb_tag),
            .rdy1_o     (wk1[i]),
            .rdy2_o     (wk2[i])
        );
    end

    // Same-cycle bypass for the op being dispatched; x0 sources are ready.
    issue_scheduler_wake #(.TAG_W(TAG_W)) u_wake_disp (
        .ps1_i      (bus.disp_ps1),
        .ps2_i      (bus.disp_ps2),
        .rdy1_i     (bus.disp_ps1_rdy | (bus.disp_ps1 == '0)),
        .rdy2_i     (bus.disp_ps2_rdy | (bus.disp_ps2 == '0)),
        .wb_valid_i (bus.wb_valid),
        .wb_tag_i   (bus.wb_tag),
        .rdy1_o     (new_rdy1),
        .rdy2_o     (new_rdy2)
    );

    // Oldest-ready select: scan from the top so the lowest index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Handshakes. Accept depends only on registered occupancy, never on
    // issue_ready, so a full queue stays closed even while it issues.
    always_comb begin
        disp_ready_w  = (occ_q < OCC_W'(DEPTH));
        issue_valid_w = sel_found && !bus.mispredict;
        fire          = issue_valid_w && bus.issue_ready;
        accept        = bus.disp_valid && disp_ready_w && !bus.mispredict;
        wr_idx        = occ_q - OCC_W'(fire);
    end

    // Issue-side outputs come straight from the selected entry.
    always_comb begin
        bus.disp_ready    = disp_ready_w;
        bus.issue_valid   = issue_valid_w;
        bus.issue_ps1     = ent_q[sel_idx].ps1;
        bus.issue_ps2     = ent_q[sel_idx].ps2;
        bus.issue_pd      = ent_q[sel_idx].pd;
        bus.issue_payload = ent_q[sel_idx].payload;
        bus.occupancy     = occ_q;
    end

    // Next queue image: wake, collapse above the issued slot, append the
    // accepted op behind the survivors, then apply any flush.
    always_comb begin
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.rdy1    = new_rdy1;
        new_ent.rdy2    = new_rdy2;
        new_ent.ps1     = bus.disp_ps1;
        new_ent.ps2     = bus.disp_ps2;
        new_ent.pd      = bus.disp_pd;
        new_ent.payload = bus.disp_payload;

        for (int i = 0; i < DEPTH; i++) begin
            woken[i]      = ent_q[i];
            woken[i].rdy1 = wk1[i];
            woken[i].rdy2 = wk2[i];
        end
        woken[DEPTH] = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (fire && (i >= int'(sel_idx))) begin
                ent_d[i] = woken[i+1];
            end else begin
                ent_d[i] = woken[i];
            end
            if (accept && (i == int'(wr_idx))) begin
                ent_d[i] = new_ent;
            end
            if (bus.mispredict) begin
                ent_d[i].valid = 1'b0;
            end
        end

        if (bus.mispredict) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(accept) - OCC_W'(fire);
        end
    end

    // State registers; reset drops every entry at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            occ_q <= occ_d;
        end
    end
endmodule
